// File: rtl/fix_add_arbiter_pkg.sv
// Shared fixed-point arbiter definitions: arbitration state encoding and
// the pointer-width helper used to size the round-robin pointer.
package fix_add_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // ceil(log2(n)) with a floor of 1 so a 2-requester pointer is still 1 bit wide.
    function automatic int unsigned ptr_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fix_add_arbiter_fix_add.sv
// Registered fixed-point adder, one cycle latency, two's complement wrap.
// The sum register is cleared whenever no operation completes.
module fix_add #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= in_valid;
            sum       <= in_valid ? (a + b) : '0;
        end
    end

endmodule

// File: rtl/fix_add_arbiter.sv
// Round-robin arbiter with grant locking that shares one registered adder
// among NREQ requesters; the grant index rides alongside as a 1-stage tag.
module fix_add_arbiter
    import fix_add_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_sum,
    output logic                  busy
);

    localparam int          PTR_W  = int'(ptr_width(NREQ));
    localparam int unsigned NREQ_U = NREQ;

    arb_state_t        state, state_nxt;
    logic [PTR_W-1:0]  ptr, ptr_nxt;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_hit;
    logic [NREQ-1:0]   grant_oh;
    logic              xfer;
    logic [NREQ-1:0]   tag_q;
    logic [WIDTH-1:0]  a_sel, b_sel;
    logic [WIDTH-1:0]  sum_q;
    logic              sum_valid;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == NREQ_U - 1) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] p,
                                                   input int unsigned k);
        return PTR_W'((32'(p) + k) % NREQ_U);
    endfunction

    // In LOCKED the pointer holds the owner, so the owner needs no separate register.
    always_comb begin
        grant_idx = '0;
        grant_hit = 1'b0;
        if (state == LOCKED) begin
            grant_idx = ptr;
            grant_hit = req_valid[ptr];
        end else begin
            for (int unsigned k = 0; k < NREQ_U; k++) begin
                if (!grant_hit && req_valid[rr_index(ptr, k)]) begin
                    grant_hit = 1'b1;
                    grant_idx = rr_index(ptr, k);
                end
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            grant_oh[i] = grant_hit && (32'(grant_idx) == i);
        end
    end

    assign req_ready = rst_n ? grant_oh : '0;
    assign xfer      = rst_n && grant_hit;
    assign a_sel     = req_a[grant_idx*WIDTH +: WIDTH];
    assign b_sel     = req_b[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ARB: begin
                if (xfer) begin
                    if (req_lock[grant_idx]) begin
                        state_nxt = LOCKED;
                        ptr_nxt   = grant_idx;
                    end else begin
                        ptr_nxt = wrap_inc(grant_idx);
                    end
                end
            end
            LOCKED: begin
                // Release on an unlocked owner transfer, or when the owner goes fully idle.
                if (xfer) begin
                    if (!req_lock[ptr]) begin
                        state_nxt = ARB;
                        ptr_nxt   = wrap_inc(ptr);
                    end
                end else if (!req_valid[ptr] && !req_lock[ptr]) begin
                    state_nxt = ARB;
                    ptr_nxt   = wrap_inc(ptr);
                end
            end
            default: begin
                state_nxt = ARB;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            ptr   <= '0;
            tag_q <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            tag_q <= xfer ? grant_oh : '0;
        end
    end

    fix_add #(
        .WIDTH(WIDTH)
    ) u_add (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (xfer),
        .a        (a_sel),
        .b        (b_sel),
        .out_valid(sum_valid),
        .sum      (sum_q)
    );

    assign resp_valid = sum_valid ? tag_q : '0;
    assign resp_sum   = sum_valid ? sum_q : '0;
    assign busy       = |resp_valid;

endmodule

// File: tb/tb_fix_add_arbiter.sv
// Scoreboard bench for fix_add_arbiter: a reference arbiter model predicts
// grants and pushes expected sums, which are popped as results appear.
module tb_fix_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  valid_d = '0;
    logic [3:0]  lock_d = '0;
    logic [63:0] a_d = '0;
    logic [63:0] b_d = '0;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [15:0] resp_sum;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          idx;
        logic [15:0] sum;
    } exp_t;

    exp_t sb[$];
    int   m_ptr = 0;
    bit   m_locked = 1'b0;

    fix_add_arbiter #(.WIDTH(16), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (valid_d),
        .req_lock  (lock_d),
        .req_a     (a_d),
        .req_b     (b_d),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_sum  (resp_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_grant(output bit hit, output int g);
        hit = 1'b0;
        g   = 0;
        if (m_locked) begin
            g   = m_ptr;
            hit = valid_d[m_ptr];
        end else begin
            for (int k = 0; k < 4; k++) begin
                int c = (m_ptr + k) % 4;
                if (!hit && valid_d[c]) begin
                    hit = 1'b1;
                    g   = c;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        m_ptr    = 0;
        m_locked = 1'b0;
        sb.delete();
    endfunction

    // One clock: sample grant at negedge, advance model at posedge, return #1 later.
    task automatic tick(output logic [3:0] obs, output logic [3:0] expv);
        bit          hit;
        int          g;
        logic [15:0] s;
        exp_t        e;
        @(negedge clk);
        obs = req_ready;
        model_grant(hit, g);
        expv = hit ? 4'(1 << g) : 4'b0000;
        @(posedge clk);
        if (hit) begin
            s     = a_d[g*16 +: 16] + b_d[g*16 +: 16];
            e.idx = g;
            e.sum = s;
            sb.push_back(e);
            if (lock_d[g]) begin
                m_locked = 1'b1;
                m_ptr    = g;
            end else begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % 4;
            end
        end else if (m_locked && !valid_d[m_ptr] && !lock_d[m_ptr]) begin
            m_locked = 1'b0;
            m_ptr    = (m_ptr + 1) % 4;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        valid_d = '0;
        lock_d  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [3:0] obs, expv;
        exp_t       e;
        logic [3:0] erv;
        logic [15:0] es;
        rst_n   = 1'b0;
        valid_d = 4'b1111;
        lock_d  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || resp_valid !== 4'b0000 || resp_sum !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rv=%b sum=%h busy=%b, required all zero",
                     req_ready, resp_valid, resp_sum, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        valid_d = 4'b0010;
        a_d[16 +: 16] = 16'h0102;
        b_d[16 +: 16] = 16'h0304;
        tick(obs, expv);
        checks++;
        if (obs !== 4'b0010) begin
            errors++;
            $display("FAIL first_xfer_after_reset: ready=%b required=0010", obs);
        end
        erv = '0; es = '0;
        if (sb.size() > 0) begin e = sb.pop_front(); erv = 4'(1 << e.idx); es = e.sum; end
        checks++;
        if (resp_valid !== erv || resp_sum !== es || resp_sum !== 16'h0406) begin
            errors++;
            $display("FAIL first_resp_after_reset: rv=%b sum=%h required rv=%b sum=0406", resp_valid, resp_sum, erv);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] obs, expv;
        exp_t       e;
        logic [3:0] erv;
        logic [15:0] es;
        apply_reset();
        valid_d = 4'b1111;
        lock_d  = '0;
        for (int i = 0; i < 8; i++) begin
            a_d = {$urandom, $urandom};
            b_d = {$urandom, $urandom};
            tick(obs, expv);
            checks++;
            if (obs !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL rr_grant[%0d]: ready=%b required=%b", i, obs, 4'(1 << (i % 4)));
            end
            erv = '0; es = '0;
            if (sb.size() > 0) begin e = sb.pop_front(); erv = 4'(1 << e.idx); es = e.sum; end
            checks++;
            if (resp_valid !== erv || resp_sum !== es || busy !== (erv != 0)) begin
                errors++;
                $display("FAIL rr_resp[%0d]: rv=%b sum=%h busy=%b required rv=%b sum=%h", i, resp_valid, resp_sum, busy, erv, es);
            end
        end
        valid_d = '0;
        tick(obs, expv);
        checks++;
        if (obs !== 4'b0000 || resp_valid !== 4'b0000 || resp_sum !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: ready=%b rv=%b sum=%h busy=%b required all zero", obs, resp_valid, resp_sum, busy);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] obs, expv;
        logic [15:0] sums [2];
        sums[0] = 16'h8000;
        sums[1] = 16'h0000;
        apply_reset();
        valid_d = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            a_d[32 +: 16] = (i == 0) ? 16'h7FFF : 16'hFFFF;
            b_d[32 +: 16] = 16'h0001;
            tick(obs, expv);
            checks++;
            if (obs !== 4'b0100) begin
                errors++;
                $display("FAIL wrap_grant[%0d]: ready=%b required=0100", i, obs);
            end
            void'(sb.pop_front());
            checks++;
            if (resp_valid !== 4'b0100 || resp_sum !== sums[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL wrap_resp[%0d]: rv=%b sum=%h busy=%b required rv=0100 sum=%h busy=1",
                         i, resp_valid, resp_sum, busy, sums[i]);
            end
        end
    endtask

    task automatic test_lock();
        logic [3:0] obs, expv;
        exp_t       e;
        logic [3:0] erv;
        logic [15:0] es;
        int         exp_g [6];
        exp_g = '{1, 1, 1, 2, 3, 0};
        apply_reset();
        valid_d = 4'b0001;
        tick(obs, expv);
        void'(sb.pop_front());
        valid_d = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            lock_d = (i < 2) ? 4'b0010 : 4'b0000;
            a_d = {$urandom, $urandom};
            b_d = {$urandom, $urandom};
            tick(obs, expv);
            checks++;
            if (obs !== 4'(1 << exp_g[i])) begin
                errors++;
                $display("FAIL lock_grant[%0d]: ready=%b required=%b", i, obs, 4'(1 << exp_g[i]));
            end
            erv = '0; es = '0;
            if (sb.size() > 0) begin e = sb.pop_front(); erv = 4'(1 << e.idx); es = e.sum; end
            checks++;
            if (resp_valid !== erv || resp_sum !== es) begin
                errors++;
                $display("FAIL lock_resp[%0d]: rv=%b sum=%h required rv=%b sum=%h", i, resp_valid, resp_sum, erv, es);
            end
        end
        lock_d = '0;
    endtask

    task automatic test_lock_drop();
        logic [3:0] obs, expv;
        logic [3:0] vseq [5];
        logic [3:0] lseq [5];
        logic [3:0] gseq [5];
        vseq = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b1111};
        lseq = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        gseq = '{4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            valid_d = vseq[i];
            lock_d  = lseq[i];
            tick(obs, expv);
            checks++;
            if (obs !== gseq[i]) begin
                errors++;
                $display("FAIL lock_drop_grant[%0d]: ready=%b required=%b", i, obs, gseq[i]);
            end
            sb.delete();
        end
        valid_d = '0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, expv;
        apply_reset();
        valid_d = 4'b0100;
        a_d[32 +: 16] = 16'h1234;
        b_d[32 +: 16] = 16'h1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_pre_grant: ready=%b required=0100", req_ready);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        valid_d = 4'b1111;
        model_reset();
        #1;
        checks++;
        if (resp_valid !== 4'b0000 || resp_sum !== 16'h0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_during: rv=%b sum=%h busy=%b ready=%b required all zero",
                     resp_valid, resp_sum, busy, req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (resp_valid !== 4'b0000 || resp_sum !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: rv=%b sum=%h busy=%b required all zero", resp_valid, resp_sum, busy);
        end
        tick(obs, expv);
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_next_grant: ready=%b required=0001", obs);
        end
        void'(sb.pop_front());
        valid_d = '0;
    endtask

    task automatic test_random();
        logic [3:0] obs, expv;
        exp_t       e;
        logic [3:0] erv;
        logic [15:0] es;
        apply_reset();
        for (int i = 0; i < 10000; i++) begin
            valid_d = 4'($urandom_range(0, 15));
            lock_d  = 4'($urandom & $urandom);
            a_d = {$urandom, $urandom};
            b_d = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) a_d[15:0] = 16'hFFFF;
            tick(obs, expv);
            checks++;
            if (obs !== expv || $countones(obs) > 1) begin
                errors++;
                $display("FAIL rand_grant[%0d]: ready=%b required=%b", i, obs, expv);
            end
            erv = '0; es = '0;
            if (sb.size() > 0) begin e = sb.pop_front(); erv = 4'(1 << e.idx); es = e.sum; end
            checks++;
            if (resp_valid !== erv || resp_sum !== es || busy !== (erv != 0)) begin
                errors++;
                $display("FAIL rand_resp[%0d]: rv=%b sum=%h busy=%b required rv=%b sum=%h",
                         i, resp_valid, resp_sum, busy, erv, es);
            end
        end
        valid_d = '0;
        lock_d  = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_lock();
        test_lock_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
